// File: rtl/dma_mem_pkg.sv
// dma_mem_pkg: shared defaults and helpers for the DMA BRAM responder
package dma_mem_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int READ_LAT_DEF = 3;
    localparam int DMA_AW = 13;
    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
        return c + 16'(en && ~&c);
    endfunction
endpackage

// File: rtl/dma_bram_responder_bram_sp.sv
// bram_sp: single-port synchronous array, write enable, 1-cycle registered read
module bram_sp
    import dma_mem_pkg::*;
#(
    parameter int AW = ADDR_W_DEF,
    parameter int DW = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/dma_bram_responder.sv
// dma_bram_responder: DMA memory-side responder, write-priority single-port array with pipelined reads
module dma_bram_responder
    import dma_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              mem_r_ready,
    input  logic [DMA_AW-1:0] mem_r_addr,
    output logic              mem_r_ack,
    output logic              mem_r_valid,
    output logic [DATA_W-1:0] mem_r_data,
    input  logic              mem_w_valid,
    input  logic [DMA_AW-1:0] mem_w_addr,
    input  logic [DATA_W-1:0] mem_w_data,
    output logic [3:0]        rd_inflight,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);
    logic we, unused_addr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata, dout;
    logic [READ_LAT-1:0] vp;
    assign we = mem_w_valid && !wb_rst_i;
    assign mem_r_ack = mem_r_ready && !mem_w_valid && !wb_rst_i;
    assign addr = mem_w_valid ? mem_w_addr[ADDR_W-1:0] : mem_r_addr[ADDR_W-1:0];
    assign unused_addr = ^{mem_r_addr[DMA_AW-1:ADDR_W], mem_w_addr[DMA_AW-1:ADDR_W]};
    bram_sp #(.AW(ADDR_W), .DW(DATA_W)) u_ram (
        .clk(wb_clk_i),
        .we(we),
        .addr(addr),
        .wdata(mem_w_data),
        .rdata(rdata)
    );
    // the array supplies one cycle of latency; the rest is a data shift pipe
    if (READ_LAT == 1) begin : g_direct
        assign dout = rdata;
    end else begin : g_pipe
        logic [DATA_W-1:0] dp [READ_LAT-1];
        always_ff @(posedge wb_clk_i) begin
            dp[0] <= rdata;
            for (int i = 1; i < READ_LAT - 1; i++) dp[i] <= dp[i-1];
        end
        assign dout = dp[READ_LAT-2];
    end
    assign mem_r_valid = vp[READ_LAT-1];
    assign mem_r_data = mem_r_valid ? dout : '0;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            vp <= '0;
            rd_inflight <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            vp <= (vp << 1) | READ_LAT'(mem_r_ack);
            rd_inflight <= rd_inflight + 4'(mem_r_ack) - 4'(mem_r_valid);
            rd_count <= sat_inc(rd_count, mem_r_ack);
            wr_count <= sat_inc(wr_count, we);
        end
    end
endmodule

// File: tb/tb_dma_bram_responder.sv
// tb_dma_bram_responder: directed table-driven checks of the DMA BRAM responder (READ_LAT 3 and 1 builds)
module tb_dma_bram_responder;
    logic clk, rst, r_ready, w_valid;
    logic [12:0] r_addr, w_addr;
    logic [31:0] w_data;
    logic ack3, v3, ack1, v1;
    logic [31:0] d3, d1;
    logic [3:0] inf3, inf1;
    logic [15:0] rc3, wc3, rc1, wc1;
    int total = 0;
    int bad = 0;

    dma_bram_responder #(.READ_LAT(3)) dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .mem_r_ready(r_ready), .mem_r_addr(r_addr), .mem_r_ack(ack3),
        .mem_r_valid(v3), .mem_r_data(d3),
        .mem_w_valid(w_valid), .mem_w_addr(w_addr), .mem_w_data(w_data),
        .rd_inflight(inf3), .rd_count(rc3), .wr_count(wc3)
    );
    dma_bram_responder #(.READ_LAT(1)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .mem_r_ready(r_ready), .mem_r_addr(r_addr), .mem_r_ack(ack1),
        .mem_r_valid(v1), .mem_r_data(d1),
        .mem_w_valid(w_valid), .mem_w_addr(w_addr), .mem_w_data(w_data),
        .rd_inflight(inf1), .rd_count(rc1), .wr_count(wc1)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [12:0] a;
        logic        ack;
        logic        v3;
        logic [31:0] d3;
        logic [3:0]  inf;
        logic        v1;
        logic [31:0] d1;
    } pv_t;
    typedef struct {
        logic [12:0] wa;
        logic [31:0] wd;
        logic [12:0] ra;
        logic [31:0] e;
    } wv_t;
    pv_t pv[12];
    wv_t wv[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [12:0] a, input logic [31:0] d);
        w_valid = 1; w_addr = a; w_data = d;
        tick;
        w_valid = 0;
    endtask

    task automatic rd(input string nm, input logic [12:0] a, input logic [31:0] e);
        r_ready = 1; r_addr = a;
        #1;
        chk({nm, "_ack"}, ack3, 1);
        chk({nm, "_ack1"}, ack1, 1);
        tick;
        r_ready = 0;
        chk({nm, "_v1"}, v1, 1);
        chk({nm, "_d1"}, d1, e);
        chk({nm, "_v3early"}, v3, 0);
        chk({nm, "_d3early"}, d3, 0);
        tick;
        tick;
        chk({nm, "_v3"}, v3, 1);
        chk({nm, "_d3"}, d3, e);
        tick;
        chk({nm, "_v3off"}, v3, 0);
    endtask

    initial begin
        pv[0]  = '{1, 13'h040, 1, 0, 32'h00, 4'd0, 0, 32'h00};
        pv[1]  = '{1, 13'h041, 1, 0, 32'h00, 4'd1, 1, 32'h11};
        pv[2]  = '{1, 13'h042, 1, 0, 32'h00, 4'd2, 1, 32'h12};
        pv[3]  = '{1, 13'h043, 1, 1, 32'h11, 4'd3, 1, 32'h13};
        pv[4]  = '{1, 13'h044, 1, 1, 32'h12, 4'd3, 1, 32'h14};
        pv[5]  = '{1, 13'h045, 1, 1, 32'h13, 4'd3, 1, 32'h15};
        pv[6]  = '{1, 13'h046, 1, 1, 32'h14, 4'd3, 1, 32'h16};
        pv[7]  = '{1, 13'h047, 1, 1, 32'h15, 4'd3, 1, 32'h17};
        pv[8]  = '{0, 13'h000, 0, 1, 32'h16, 4'd3, 1, 32'h18};
        pv[9]  = '{0, 13'h000, 0, 1, 32'h17, 4'd2, 0, 32'h00};
        pv[10] = '{0, 13'h000, 0, 1, 32'h18, 4'd1, 0, 32'h00};
        pv[11] = '{0, 13'h000, 0, 0, 32'h00, 4'd0, 0, 32'h00};
        wv[0] = '{13'h1400, 32'h0000DEAD, 13'h0000, 32'h0000DEAD};
        wv[1] = '{13'h0005, 32'h12345678, 13'h1C05, 32'h12345678};
        wv[2] = '{13'h03FF, 32'hCAFEF00D, 13'h1FFF, 32'hCAFEF00D};
        wv[3] = '{13'h0800, 32'h0000BEEF, 13'h0400, 32'h0000BEEF};

        rst = 1; r_ready = 1; r_addr = 13'h040; w_valid = 0; w_addr = 0; w_data = 0;
        #1;
        chk("rst_ack", ack3, 0);
        tick;
        tick;
        rst = 0; r_ready = 0;
        #1;
        chk("rst_v3", v3, 0);
        chk("rst_d3", d3, 0);
        chk("rst_inf", inf3, 0);
        chk("rst_rc", rc3, 0);
        chk("rst_wc", wc3, 0);
        chk("rst_v1", v1, 0);

        for (int i = 0; i < 8; i++) wr(13'h040 + 13'(i), 32'h11 + 32'(i));
        chk("wr8_wc", wc3, 8);
        for (int i = 0; i < 12; i++) begin
            r_ready = pv[i].rdy; r_addr = pv[i].a;
            #1;
            chk($sformatf("b2b%0d_ack", i), ack3, pv[i].ack);
            chk($sformatf("b2b%0d_v3", i), v3, pv[i].v3);
            chk($sformatf("b2b%0d_d3", i), d3, pv[i].d3);
            chk($sformatf("b2b%0d_inf", i), inf3, pv[i].inf);
            chk($sformatf("b2b%0d_v1", i), v1, pv[i].v1);
            chk($sformatf("b2b%0d_d1", i), d1, pv[i].d1);
            tick;
        end
        chk("b2b_rc", rc3, 8);

        w_valid = 1; w_addr = 13'h010; w_data = 32'hA5; r_ready = 1; r_addr = 13'h010;
        #1;
        chk("conf_ack0", ack3, 0);
        tick;
        chk("conf_ack1", ack3, 0);
        tick;
        w_valid = 0;
        rd("conf_rd", 13'h010, 32'hA5);
        chk("conf_wc", wc3, 10);
        chk("conf_rc", rc3, 9);

        for (int i = 0; i < 4; i++) begin
            wr(wv[i].wa, wv[i].wd);
            rd($sformatf("wrap%0d", i), wv[i].ra, wv[i].e);
        end
        chk("wrap_wc", wc3, 14);
        chk("wrap_rc", rc3, 13);

        for (int i = 0; i < 3; i++) begin
            r_ready = 1; r_addr = 13'h040 + 13'(i);
            #1;
            chk($sformatf("mid%0d_ack", i), ack3, 1);
            tick;
        end
        rst = 1; r_ready = 1; r_addr = 13'h043; w_valid = 1; w_addr = 13'h040; w_data = 32'hBAD;
        #1;
        chk("mid_rst_ack", ack3, 0);
        chk("mid_rst_v3", v3, 1);
        chk("mid_rst_d3", d3, 32'h11);
        tick;
        rst = 0; r_ready = 0; w_valid = 0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drop%0d_v3", i), v3, 0);
            chk($sformatf("drop%0d_d3", i), d3, 0);
            chk($sformatf("drop%0d_v1", i), v1, 0);
            tick;
        end
        chk("drop_inf", inf3, 0);
        chk("drop_rc", rc3, 0);
        chk("drop_wc", wc3, 0);
        rd("post_rst", 13'h040, 32'h11);
        chk("post_rst_rc", rc3, 1);

        rst = 1;
        tick;
        rst = 0; r_ready = 1;
        for (int n = 1; n <= 65540; n++) begin
            r_addr = 13'(n);
            tick;
            if (n == 65534) chk("sat_fffe", rc3, 16'hFFFE);
            if (n == 65535) chk("sat_ffff", rc3, 16'hFFFF);
        end
        chk("sat_hold", rc3, 16'hFFFF);
        chk("sat_hold1", rc1, 16'hFFFF);
        chk("sat_inf3", inf3, 3);
        chk("sat_inf1", inf1, 1);
        chk("sat_v3", v3, 1);
        r_ready = 0;
        repeat (5) tick;
        chk("sat_after", rc3, 16'hFFFF);
        chk("sat_inf_drain", inf3, 0);
        chk("sat_v_drain", v3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_bram_responder.md
DMA_BRAM_RESPONDER -- requirements
Module: dma_bram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address bits actually decoded (array depth 2^ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter READ_LAT, default 3, legal range 1..15, cycles from read accept to mem_r_valid.
REQ-004 SHALL have port wb_clk_i  in  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port mem_r_ready  in  1  DMA read request valid (mem_r_addr valid).
REQ-007 SHALL have port mem_r_addr  in  13  DMA read word address.
REQ-008 SHALL have port mem_r_ack  out  1  read request accepted this cycle.
REQ-009 SHALL have port mem_r_valid  out  1  mem_r_data valid this cycle.
REQ-010 SHALL have port mem_r_data  out  DATA_W  read return data.
REQ-011 SHALL have port mem_w_valid  in  1  write strobe, one word per cycle, no ack.
REQ-012 SHALL have port mem_w_addr  in  13  write word address.
REQ-013 SHALL have port mem_w_data  in  DATA_W  write data.
REQ-014 SHALL have port rd_inflight  out  4  reads accepted but not yet returned.
REQ-015 SHALL have port rd_count  out  16  total reads accepted since reset, saturating.
REQ-016 SHALL have port wr_count  out  16  total writes performed since reset, saturating.

Function
REQ-017 SHALL be the memory-side responder to the DMA read/write port: single-port array, at most one access per cycle.
REQ-018 SHALL perform a write on every cycle with mem_w_valid=1, unconditionally (writes never stall, never dropped).
REQ-019 SHALL drive mem_r_ack combinationally = mem_r_ready && !mem_w_valid && !wb_rst_i (write priority; blocked read held by requester, retried).
REQ-020 SHALL, for a read accepted at cycle T, assert mem_r_valid for exactly one cycle at T+READ_LAT with the array word at mem_r_addr as of cycle T.
REQ-021 SHALL accept back-to-back reads every cycle; returns in accept order, one per cycle, fully pipelined (shift pipeline of valid+data, depth READ_LAT).
REQ-022 SHALL make a write at cycle T visible to any read accepted at T+1 or later (read-after-write, no stale data).
REQ-023 SHALL decode only address bits [ADDR_W-1:0]; upper bits ignored, addresses wrap modulo 2^ADDR_W for both read and write.
REQ-024 SHALL drive mem_r_data = 0 whenever mem_r_valid = 0.
REQ-025 SHALL update rd_inflight: +1 on accept, -1 on mem_r_valid, unchanged when both in same cycle; never exceeds READ_LAT.
REQ-026 SHALL increment rd_count per accepted read and wr_count per write, each holding at 16'hFFFF.

Reset
REQ-027 SHALL, with wb_rst_i=1 at a clock edge, clear pipeline valid bits, rd_inflight, rd_count, wr_count; mem_r_valid=0, mem_r_ack=0, mem_r_data=0 from next cycle.
REQ-028 SHALL drop reads in flight when reset asserts mid-operation; no mem_r_valid for them after reset.
REQ-029 SHALL NOT reset or initialise array contents; writes asserted during reset SHALL be ignored.

Structure
REQ-030 SHALL place ADDR_W, DATA_W, READ_LAT defaults and the 13-bit DMA address width constant in shared package dma_mem_pkg.
REQ-031 SHALL instantiate one sub-module bram_sp (single-port synchronous array, 1-cycle read, write enable); remaining READ_LAT-1 cycles as output pipeline in this block.

Verification
REQ-032 SHALL test: write 0x11..0x18 to addr 0x040..0x047, then 8 back-to-back reads from cycle T -> mem_r_ack high 8 cycles, mem_r_valid T+3..T+10 with 0x11..0x18, rd_inflight peaks at 3.
REQ-033 SHALL test: mem_r_ready and mem_w_valid both high 2 cycles (write 0xA5 to 0x010, read 0x010) -> ack=0 those cycles, read accepted 3rd cycle, returns 0xA5.
REQ-034 SHALL test: write 0xDEAD to 0x1400 (ADDR_W=10) -> read 0x000 returns 0xDEAD (wrap).
REQ-035 SHALL test: 3 reads accepted, wb_rst_i pulsed 1 cycle at T+1 -> no mem_r_valid afterward, rd_inflight=0, rd_count=0.
REQ-036 SHALL test: 65540 continuous reads -> rd_count=0xFFFF and holds; READ_LAT=1 build returns data at T+1.
